// File: rtl/fetch_stage_pkg.sv
// Shared core constants and IF/ID payload type for the fetch stage and its consumers.
package fetch_stage_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned INST_W = 32;
   localparam int unsigned PC_W   = XLEN;

   localparam logic [PC_W-1:0]   RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [INST_W-1:0] NOP_INST_DEF  = 32'h0000_0000;
   localparam logic [PC_W-1:0]   PC_INC        = 32'd4;
   localparam logic [PC_W-1:0]   PC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pc4;
      logic              valid;
   } if_id_t;

   // Word-align a byte address by clearing its two low bits.
   function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
      return addr & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble and beats hold; hold freezes contents.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   hold_i,
   input  logic   flush_i,
   input  if_id_t d_i,
   output if_id_t q_o
);

   if_id_t bubble_c;
   if_id_t q_q;
   if_id_t q_d;

   assign bubble_c = '{inst: NOP_INST, pc4: '0, valid: 1'b0};

   always_comb begin
      q_d = q_q;
      if (flush_i) begin
         q_d = bubble_c;
      end else if (!hold_i) begin
         q_d = d_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= bubble_c;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [PC_W-1:0]   RESET_PC = RESET_PC_DEF,
   parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [INST_W-1:0] imem_data,
   input  logic              stall,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic [PC_W-1:0]   pc,
   output logic [INST_W-1:0] if_id_inst,
   output logic [PC_W-1:0]   if_id_pc4,
   output logic              if_id_valid
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] pc_inc_c;
   if_id_t          if_id_d_c;
   if_id_t          if_id_q;

   assign pc_inc_c = pc_q + PC_INC;

   // Redirect wins over stall so a wrong-path fetch can never be held.
   always_comb begin
      pc_d = pc_q;
      if (redirect) begin
         pc_d = word_align(redirect_pc);
      end else if (!stall) begin
         pc_d = pc_inc_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= word_align(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign if_id_d_c = '{inst: imem_data, pc4: pc_inc_c, valid: 1'b1};

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold_i  (stall),
      .flush_i (redirect),
      .d_i     (if_id_d_c),
      .q_o     (if_id_q)
   );

   assign imem_addr   = pc_q >> 2;
   assign pc          = pc_q;
   assign if_id_inst  = if_id_q.inst;
   assign if_id_pc4   = if_id_q.pc4;
   assign if_id_valid = if_id_q.valid;

endmodule
